// File: rtl/ldpc_pkg.sv
// Shared definitions for the 16-bit (8 data + 8 parity) LDPC code:
// group masks, check-to-group map, FSM states and the syndrome function.
package ldpc_pkg;

    localparam int N = 16;
    localparam int K = 8;
    localparam int M = 8;

    localparam logic [7:0] G_A = 8'h92;
    localparam logic [7:0] G_B = 8'h49;
    localparam logic [7:0] G_C = 8'h24;

    // Data mask used by check j, index 7 first
    localparam logic [M-1:0][K-1:0] CHK_MASK = {
        G_B, G_A, G_C, G_B, G_A, G_C, G_B, G_A
    };

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_OUT
    } state_t;

    function automatic logic [M-1:0] syndrome(input logic [N-1:0] cw);
        logic [M-1:0] s;
        s = '0;
        for (int j = 0; j < M; j++) begin
            s[j] = (^(cw[K-1:0] & CHK_MASK[j])) ^ cw[K+j];
        end
        return s;
    endfunction

endpackage

// File: rtl/ldpc_flip_select.sv
// Combinational flip selection: syndrome, per-bit unsatisfied counts and
// the highest-index bit holding the maximum count.
module ldpc_flip_select
    import ldpc_pkg::*;
(
    input  logic [15:0] cw,
    output logic [7:0]  syn,
    output logic [3:0]  flip_idx,
    output logic        flip_en
);

    logic [1:0] cnt [N];
    logic [1:0] max_cnt;

    always_comb begin
        syn = syndrome(cw);
        for (int i = 0; i < N; i++) begin
            cnt[i] = 2'd0;
        end
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < M; j++) begin
                cnt[i] = cnt[i] + {1'b0, syn[j] & CHK_MASK[j][i]};
            end
        end
        for (int j = 0; j < M; j++) begin
            cnt[K+j] = {1'b0, syn[j]};
        end
    end

    // >= lets the later (higher) index win every tie
    always_comb begin
        max_cnt  = 2'd0;
        flip_idx = 4'd0;
        for (int i = 0; i < N; i++) begin
            if (cnt[i] >= max_cnt) begin
                max_cnt  = cnt[i];
                flip_idx = 4'(i);
            end
        end
        flip_en = (syn != 8'd0);
    end

endmodule

// File: rtl/ldpc_bitflip_decoder.sv
// Iterative single-flip-per-cycle LDPC decoder with valid/ready handshakes
// on both the codeword input and the result output.
module ldpc_bitflip_decoder
    import ldpc_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int CODEWORD_WIDTH = 16,
    parameter int MAX_ITER       = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CODEWORD_WIDTH-1:0] codeword_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     data_out,
    output logic [CODEWORD_WIDTH-1:0] codeword_out,
    output logic [3:0]                flip_count,
    output logic                      error_corrected,
    output logic                      error_detected
);

    state_t      state_q, state_d;
    logic [15:0] work_q, work_d;
    logic [15:0] orig_q, orig_d;
    logic [3:0]  iter_q, iter_d;
    logic [7:0]  data_q, data_d;
    logic [15:0] cw_out_q, cw_out_d;
    logic [3:0]  flips_q, flips_d;
    logic        corr_q, corr_d;
    logic        det_q, det_d;

    logic [7:0]  syn;
    logic [3:0]  flip_idx;
    logic        flip_en;

    ldpc_flip_select u_sel (
        .cw       (work_q),
        .syn      (syn),
        .flip_idx (flip_idx),
        .flip_en  (flip_en)
    );

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        orig_d   = orig_q;
        iter_d   = iter_q;
        data_d   = data_q;
        cw_out_d = cw_out_q;
        flips_d  = flips_q;
        corr_d   = corr_q;
        det_d    = det_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    work_d  = codeword_in;
                    orig_d  = codeword_in;
                    iter_d  = 4'd0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!flip_en) begin
                    data_d   = work_q[7:0];
                    cw_out_d = work_q;
                    flips_d  = iter_q;
                    corr_d   = (iter_q != 4'd0);
                    det_d    = 1'b0;
                    state_d  = S_OUT;
                end else if (iter_q == 4'(MAX_ITER)) begin
                    // Failure reports the untouched input data
                    data_d   = orig_q[7:0];
                    cw_out_d = work_q;
                    flips_d  = iter_q;
                    corr_d   = 1'b0;
                    det_d    = 1'b1;
                    state_d  = S_OUT;
                end else begin
                    work_d = work_q ^ (16'd1 << flip_idx);
                    iter_d = iter_q + 4'd1;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            work_q   <= '0;
            orig_q   <= '0;
            iter_q   <= '0;
            data_q   <= '0;
            cw_out_q <= '0;
            flips_q  <= '0;
            corr_q   <= 1'b0;
            det_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            orig_q   <= orig_d;
            iter_q   <= iter_d;
            data_q   <= data_d;
            cw_out_q <= cw_out_d;
            flips_q  <= flips_d;
            corr_q   <= corr_d;
            det_q    <= det_d;
        end
    end

    assign in_ready        = (state_q == S_IDLE);
    assign out_valid       = (state_q == S_OUT);
    assign data_out        = data_q;
    assign codeword_out    = cw_out_q;
    assign flip_count      = flips_q;
    assign error_corrected = corr_q;
    assign error_detected  = det_q;

endmodule

// File: tb/tb_ldpc_bitflip_decoder.sv
// Directed, table-driven bench for ldpc_bitflip_decoder (MAX_ITER=4).
module tb_ldpc_bitflip_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] codeword_in;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  data_out;
    logic [15:0] codeword_out;
    logic [3:0]  flip_count;
    logic        error_corrected;
    logic        error_detected;

    int errors = 0;
    int checks = 0;

    ldpc_bitflip_decoder #(
        .DATA_WIDTH     (8),
        .CODEWORD_WIDTH (16),
        .MAX_ITER       (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .codeword_in     (codeword_in),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .data_out        (data_out),
        .codeword_out    (codeword_out),
        .flip_count      (flip_count),
        .error_corrected (error_corrected),
        .error_detected  (error_detected)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] cw;
        logic [7:0]  data;
        logic [15:0] cw_out;
        logic [3:0]  flips;
        logic        corr;
        logic        det;
        int          lat;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Waits for out_valid after an accept edge; returns edges taken
    task automatic wait_out(output int cyc);
        cyc = 0;
        while (cyc < 40) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (out_valid) break;
        end
        if (!out_valid) begin
            errors++;
            checks++;
            $display("FAIL timeout: out_valid %b expected 1", out_valid);
        end
    endtask

    task automatic send(input logic [15:0] cw);
        int guard;
        guard = 0;
        while (!in_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        in_valid    = 1'b1;
        codeword_in = cw;
        @(posedge clk);
        @(negedge clk);
        in_valid    = 1'b0;
        codeword_in = 16'hFFFF;
        check("in_ready_busy", {15'd0, in_ready}, 16'd0);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("rel_out_valid", {15'd0, out_valid}, 16'd0);
        check("rel_in_ready", {15'd0, in_ready}, 16'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int cyc;
        send(v.cw);
        wait_out(cyc);
        check("latency", 16'(cyc), 16'(v.lat));
        check("data_out", {8'd0, data_out}, {8'd0, v.data});
        check("codeword_out", codeword_out, v.cw_out);
        check("flip_count", {12'd0, flip_count}, {12'd0, v.flips});
        check("corrected", {15'd0, error_corrected}, {15'd0, v.corr});
        check("detected", {15'd0, error_detected}, {15'd0, v.det});
        release_out();
    endtask

    initial begin
        int cyc;
        logic [7:0]  h_data;
        logic [15:0] h_cw;
        logic [3:0]  h_fl;
        logic        seen;

        vecs[0] = '{16'hDBA5, 8'hA5, 16'hDBA5, 4'd0, 1'b0, 1'b0, 1};
        vecs[1] = '{16'hDFA5, 8'hA5, 16'hDBA5, 4'd1, 1'b1, 1'b0, 2};
        vecs[2] = '{16'h0010, 8'h90, 16'h0090, 4'd1, 1'b1, 1'b0, 2};
        vecs[3] = '{16'h1F00, 8'h00, 16'hDFC0, 4'd4, 1'b0, 1'b1, 5};
        vecs[4] = '{16'h0000, 8'h00, 16'h0000, 4'd0, 1'b0, 1'b0, 1};
        vecs[5] = '{16'h0001, 8'h41, 16'h0041, 4'd1, 1'b1, 1'b0, 2};
        vecs[6] = '{16'h0004, 8'h24, 16'h0024, 4'd1, 1'b1, 1'b0, 2};
        vecs[7] = '{16'h8000, 8'h00, 16'h0000, 4'd1, 1'b1, 1'b0, 2};
        vecs[8] = '{16'hDBFF, 8'hFF, 16'hDBFF, 4'd0, 1'b0, 1'b0, 1};

        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        codeword_in = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("rst_in_ready", {15'd0, in_ready}, 16'd1);
        check("rst_out_valid", {15'd0, out_valid}, 16'd0);
        check("rst_data", {8'd0, data_out}, 16'd0);
        check("rst_cw", codeword_out, 16'd0);
        check("rst_flips", {12'd0, flip_count}, 16'd0);
        check("rst_flags", {14'd0, error_corrected, error_detected}, 16'd0);

        // out_ready while idle must not matter
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_rdy_ign", {15'd0, out_valid}, 16'd0);

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i]);
        end

        // Back-pressure: hold result for 10 cycles with new input offered
        send(16'hDFA5);
        wait_out(cyc);
        h_data = data_out;
        h_cw   = codeword_out;
        h_fl   = flip_count;
        check("hold_data0", {8'd0, h_data}, 16'h00A5);
        check("hold_cw0", h_cw, 16'hDBA5);
        in_valid    = 1'b1;
        codeword_in = 16'h1F00;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", {15'd0, out_valid}, 16'd1);
            check("hold_in_ready", {15'd0, in_ready}, 16'd0);
            check("hold_data", {8'd0, data_out}, 16'h00A5);
            check("hold_cw", codeword_out, 16'hDBA5);
            check("hold_flips", {12'd0, flip_count}, 16'd1);
            check("hold_corr", {15'd0, error_corrected}, 16'd1);
        end
        in_valid = 1'b0;
        release_out();

        // Reset while 0x1F00 is mid-iteration
        send(16'h1F00);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("mrst_in_ready", {15'd0, in_ready}, 16'd1);
        check("mrst_out_valid", {15'd0, out_valid}, 16'd0);
        check("mrst_data", {8'd0, data_out}, 16'd0);
        check("mrst_cw", codeword_out, 16'd0);
        check("mrst_flips", {12'd0, flip_count}, 16'd0);
        check("mrst_flags", {14'd0, error_corrected, error_detected}, 16'd0);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("mrst_no_out", {15'd0, seen}, 16'd0);
        run_vec(vecs[1]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
